div_multicycle: RTL and testbench

- Multicycle signed 32-bit integer divider for the processor's multdiv path. It is the inverse operation to the multiplier.
- Operands are converted to magnitudes by conditional two's-complement negation (bitwise invert plus one). The block then runs a radix-2 restoring divide over WIDTH cycles and restores the signs of the quotient and remainder.
- The pipeline's multdiv stalls on it, holding until it receives the one-cycle ready pulse.

---
 rtl/multdiv_pkg.sv | 21 ++
 rtl/cond_negate.sv | 19 +
 rtl/div_multicycle.sv | 164 ++++++++++++++++
 tb/tb_div_multicycle.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv path.
//   state_e   : divider FSM encoding (IDLE/RUN/DONE)
//   cnt_width : iteration counter width for a given operand width
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DivWidth = 32;

    // One extra bit so the counter can hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    localparam int unsigned DivCntW = cnt_width(DivWidth);

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: out_o = neg_i ? (~in_i + 1) : in_i.
//   in_i  : WIDTH-bit input value
//   neg_i : negate when high
//   out_o : WIDTH-bit result
module cond_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] inv;

    // XOR with a replicated neg_i is the bitwise-invert array; adding neg_i is the incrementer.
    assign inv   = in_i ^ {WIDTH{neg_i}};
    assign out_o = inv + WIDTH'(neg_i);

endmodule

// File: rtl/div_multicycle.sv
// Multicycle signed integer divider, radix-2 restoring, one quotient bit per cycle.
//   clock, reset_n   : rising-edge clock, asynchronous active-low reset
//   ctrl_div         : start pulse, operands sampled on the edge where it is high
//   data_operandA/B  : dividend / divisor, two's complement
//   data_result      : quotient, truncated toward zero
//   data_remainder   : remainder, sign follows the dividend
//   data_exception   : divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY   : one-cycle result-valid pulse
module div_multicycle
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exception_q, exception_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] abs_a, abs_b, quo_fixed, rem_fixed;
    logic [WIDTH:0]   shifted, trial;

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (
        .in_i  (data_operandA),
        .neg_i (data_operandA[WIDTH-1]),
        .out_o (abs_a)
    );

    cond_negate #(.WIDTH(WIDTH)) u_abs_b (
        .in_i  (data_operandB),
        .neg_i (data_operandB[WIDTH-1]),
        .out_o (abs_b)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .in_i  (quo_q),
        .neg_i (sign_quo_q),
        .out_o (quo_fixed)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .in_i  (rem_q),
        .neg_i (sign_rem_q),
        .out_o (rem_fixed)
    );

    // Shift the next dividend bit into the partial remainder; WIDTH+1 bits so the
    // unsigned magnitude 2^(WIDTH-1) never loses its top bit.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor_q};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        div0_d      = div0_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exception_d = exception_q;
        rdy_d       = 1'b0;

        // A start in any state wins, which is what aborts an operation in flight.
        if (ctrl_div) begin
            divisor_d   = abs_b;
            quo_d       = abs_a;
            rem_d       = '0;
            count_d     = '0;
            sign_quo_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            sign_rem_d  = data_operandA[WIDTH-1];
            div0_d      = (data_operandB == '0);
            exception_d = 1'b0;
            state_d     = (data_operandB == '0) ? DONE : RUN;
        end else begin
            case (state_q)
                IDLE: begin
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    count_d = count_q + CntW'(1);
                    if (count_q == LastIter) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    result_d    = div0_q ? '0 : quo_fixed;
                    remainder_d = div0_q ? '0 : rem_fixed;
                    exception_d = div0_q;
                    rdy_d       = 1'b1;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            div0_q      <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            div0_q      <= div0_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exception_q <= exception_d;
            rdy_q       <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exception_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_div_multicycle.sv
// Self-checking bench for div_multicycle: directed steps plus a few random operand pairs,
// expected results queued at start time and compared when the ready pulse arrives.
module tb_div_multicycle;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        ctrl_div = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
    } exp_t;

    exp_t sb[$];

    div_multicycle #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t m;
        if (b == 32'd0) begin
            m.q = '0;
            m.r = '0;
            m.e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m.q = 32'h8000_0000;
            m.r = '0;
            m.e = 1'b0;
        end else begin
            m.q = $signed(a) / $signed(b);
            m.r = $signed(a) % $signed(b);
            m.e = 1'b0;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one capture edge; ctrl_div drops at the following negedge.
    task automatic start(input logic [31:0] a, input logic [31:0] b, input bit expect_done);
        @(negedge clock);
        ctrl_div      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        if (expect_done) sb.push_back(model(a, b));
        @(posedge clock);
        @(negedge clock);
        ctrl_div      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Waits (bounded) for the ready pulse, checks latency, pops and compares, then
    // checks the pulse is one cycle wide and the outputs hold.
    task automatic wait_rdy(input string tag, input int exp_lat);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                check({tag, " result"}, data_result, e.q);
                check({tag, " remainder"}, data_remainder, e.r);
                check({tag, " exception"}, 32'(data_exception), 32'(e.e));
                @(negedge clock);
                check({tag, " pulse width"}, 32'(data_resultRDY), 32'd0);
                check({tag, " result hold"}, data_result, e.q);
            end
        end
    endtask

    task automatic no_rdy(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (data_resultRDY) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        // Reset state
        #3 reset_n = 1'b0;
        #2;
        check("reset result", data_result, 32'd0);
        check("reset remainder", data_remainder, 32'd0);
        check("reset exception", 32'(data_exception), 32'd0);
        check("reset rdy", 32'(data_resultRDY), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Basic and mixed-sign cases
        start(32'd7, 32'd2, 1'b1);
        wait_rdy("7/2", 33);
        start(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_rdy("-7/2", 33);
        start(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_rdy("7/-2", 33);

        // Divide by zero, then a normal op must clear the exception
        start(32'd5, 32'd0, 1'b1);
        wait_rdy("5/0", 1);
        start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_rdy("min/-1", 33);
        start(32'h7FFF_FFFF, 32'd1, 1'b1);
        wait_rdy("max/1", 33);

        // Restart mid-run: only the second operation completes
        start(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clock);
        start(32'd9, 32'd3, 1'b1);
        wait_rdy("restart", 33);
        no_rdy("restart single rdy", 40);
        check("restart queue empty", 32'(sb.size()), 32'd0);

        // ctrl_div held high keeps re-capturing; only the final capture completes
        @(negedge clock);
        ctrl_div      = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        no_rdy("held ctrl_div", 40);
        sb.push_back(model(32'd45, 32'hFFFF_FFF9));
        data_operandA = 32'd45;
        data_operandB = 32'hFFFF_FFF9;
        @(posedge clock);
        @(negedge clock);
        ctrl_div = 1'b0;
        wait_rdy("held release", 33);

        // Asynchronous reset mid-run
        start(32'd1000, 32'd3, 1'b0);
        repeat (14) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrun reset result", data_result, 32'd0);
        check("midrun reset remainder", data_remainder, 32'd0);
        check("midrun reset exception", 32'(data_exception), 32'd0);
        check("midrun reset rdy", 32'(data_resultRDY), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        no_rdy("midrun reset no rdy", 40);
        start(32'd20, 32'd6, 1'b1);
        wait_rdy("20/6", 33);

        // Random operand pairs, divisor sizes spread out
        for (int k = 0; k < 6; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 30);
            if (b == 32'd0) b = 32'd1;
            if ($urandom_range(0, 1) == 1) b = -b;
            start(a, b, 1'b1);
            wait_rdy("random", 33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
